// File: rtl/acc_bank_pkg.sv
// Shared definitions for the accumulator bank / UART readback block.
package acc_bank_pkg;
    localparam int NLANES       = 16;
    localparam int SEL_W        = 4;
    localparam int CLKS_PER_BIT = 868;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_t;
endpackage

// File: rtl/acc_bank_tx_uart.sv
// 8N1 byte transmitter: start bit, 8 data bits LSB first, stop bit, each CLKS_PER_BIT clocks.
module uart_tx_byte
    import acc_bank_pkg::*;
#(
    parameter int CLKS_PER_BIT = acc_bank_pkg::CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       line,
    output logic       active
);
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_bit;
    logic [7:0]       r_data;
    logic             r_busy;
    logic             r_line;
    logic             w_tick;

    assign w_tick = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign line   = r_line;
    // Drops in the last stop-bit clock so the caller leaves SEND exactly on the frame boundary.
    assign active = r_busy & ~(w_tick & (r_bit == 4'd9));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_bit  <= '0;
            r_data <= '0;
            r_busy <= 1'b0;
            r_line <= 1'b1;
        end else if (!r_busy) begin
            if (start) begin
                r_busy <= 1'b1;
                r_data <= data;
                r_bit  <= '0;
                r_cnt  <= '0;
                r_line <= 1'b0;
            end
        end else if (w_tick) begin
            r_cnt <= '0;
            if (r_bit == 4'd9) begin
                r_busy <= 1'b0;
                r_line <= 1'b1;
            end else begin
                r_bit  <= r_bit + 4'd1;
                r_line <= (r_bit == 4'd8) ? 1'b1 : r_data[r_bit[2:0]];
            end
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/acc_bank_tx.sv
// Bit-serial frame deserialiser feeding round-robin accumulator lanes, with a
// snapshot readback of every lane over UART, stepped by the controller's sel.
module acc_bank_tx
    import acc_bank_pkg::*;
#(
    parameter int NLANES       = acc_bank_pkg::NLANES,
    parameter int SEL_W        = acc_bank_pkg::SEL_W,
    parameter int CLKS_PER_BIT = acc_bank_pkg::CLKS_PER_BIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             acc,
    input  logic             clear,
    input  logic             sdata,
    input  logic             out,
    input  logic [SEL_W-1:0] sel,
    output logic             busy,
    output logic             uart_tx,
    output logic             drop
);
    state_t           r_state;
    state_t           w_next;
    logic [7:0]       r_shreg;
    logic [3:0]       r_cnt;
    logic             r_byte_done;
    logic [7:0]       r_lane [NLANES];
    logic [7:0]       r_snap [NLANES];
    logic [SEL_W-1:0] r_ptr;
    logic [SEL_W-1:0] w_ptr_nxt;
    logic [SEL_W-1:0] r_sel_q;
    logic             r_drop;
    logic             w_snap_go;
    logic             w_start;
    logic             w_active;
    logic [7:0]       w_txbyte;

    assign w_snap_go = (r_state == IDLE) && out;
    assign w_ptr_nxt = (r_ptr == SEL_W'(NLANES - 1)) ? '0 : r_ptr + 1'b1;
    assign w_txbyte  = r_snap[sel];
    assign drop      = r_drop;

    // Deserialiser: clear wins over acc; samples beyond the 8th wait for the next clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shreg     <= '0;
            r_cnt       <= '0;
            r_byte_done <= 1'b0;
        end else begin
            r_byte_done <= acc && !clear && (r_cnt == 4'd7);
            if (clear) begin
                r_cnt <= '0;
            end else if (acc && (r_cnt < 4'd8)) begin
                r_shreg <= {r_shreg[6:0], sdata};
                r_cnt   <= r_cnt + 4'd1;
            end
        end
    end

    // A frame finishing in the snapshot cycle lands in the freshly zeroed lane 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NLANES; i++) begin
                r_lane[i] <= '0;
                r_snap[i] <= '0;
            end
            r_ptr <= '0;
        end else if (w_snap_go) begin
            for (int i = 0; i < NLANES; i++) begin
                r_snap[i] <= r_lane[i];
                r_lane[i] <= '0;
            end
            if (r_byte_done) begin
                r_lane[0] <= r_shreg;
                r_ptr     <= SEL_W'(1);
            end else begin
                r_ptr <= '0;
            end
        end else if (r_byte_done) begin
            r_lane[r_ptr] <= r_lane[r_ptr] + r_shreg;
            r_ptr         <= w_ptr_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_sel_q <= '0;
            r_drop  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == LOAD) begin
                r_sel_q <= sel;
            end
            if (out && (r_state != IDLE)) begin
                r_drop <= 1'b1;
            end
        end
    end

    // busy follows out in IDLE so sel cannot move in the very cycle readback is requested.
    always_comb begin
        w_next  = r_state;
        busy    = 1'b0;
        w_start = 1'b0;
        case (r_state)
            IDLE: begin
                busy = out;
                if (out) begin
                    w_next = LOAD;
                end
            end
            LOAD: begin
                busy    = 1'b1;
                w_start = 1'b1;
                w_next  = SEND;
            end
            SEND: begin
                busy = 1'b1;
                if (!w_active) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                w_next = (r_sel_q == SEL_W'(NLANES - 1)) ? IDLE : LOAD;
            end
            default: w_next = IDLE;
        endcase
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk   (clk),
        .rst   (rst),
        .start (w_start),
        .data  (w_txbyte),
        .line  (uart_tx),
        .active(w_active)
    );
endmodule

// File: tb/tb_acc_bank_tx.sv
// Scoreboard bench: readback stimulus queues expected bytes, a UART monitor decodes and compares.
module tb_acc_bank_tx;
    import acc_bank_pkg::*;

    localparam int CPB = 4;
    localparam int NL  = 16;
    localparam int PER = 10 * CPB + 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       acc = 1'b0;
    logic       clear = 1'b0;
    logic       sdata = 1'b0;
    logic       out = 1'b0;
    logic [3:0] sel = '0;
    logic       busy;
    logic       uart_tx;
    logic       drop;

    int n_checks = 0;
    int n_fail   = 0;
    int n_rx     = 0;

    logic [7:0] exp_q[$];
    logic [7:0] m_lane[NL];
    int         m_ptr = 0;
    bit         pend = 0;
    logic [7:0] pend_b = '0;

    acc_bank_tx #(.NLANES(NL), .SEL_W(4), .CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst(rst), .acc(acc), .clear(clear), .sdata(sdata),
        .out(out), .sel(sel), .busy(busy), .uart_tx(uart_tx), .drop(drop)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit tail);
        @(posedge clk); #1; clear = 1'b1; acc = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            @(posedge clk); #1; clear = 1'b0; acc = 1'b1; sdata = b[i];
        end
        if (tail) begin
            @(posedge clk); #1; acc = 1'b0;
            @(posedge clk); #1;
            m_lane[m_ptr] = m_lane[m_ptr] + b;
            m_ptr = (m_ptr + 1) % NL;
        end else begin
            pend   = 1'b1;
            pend_b = b;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic readback(input int drop_byte, input int abort_byte);
        int dones, cyc, t_prev, n_push;
        bit dropped;
        logic [7:0] lane_or;
        n_push = (abort_byte >= 0) ? abort_byte : NL;
        for (int k = 0; k < n_push; k++) exp_q.push_back(m_lane[k]);
        for (int k = 0; k < NL; k++) m_lane[k] = '0;
        m_ptr = 0;
        if (pend) begin
            m_lane[0] = pend_b;
            m_ptr = 1;
            pend = 1'b0;
        end
        @(posedge clk); #1; acc = 1'b0; clear = 1'b0; sel = '0; out = 1'b1;
        @(negedge clk); check("busy_out_cycle", busy, 1);
        @(posedge clk); #1; out = 1'b0;
        @(negedge clk); check("line_high_load", uart_tx, 1);
        @(negedge clk); check("first_start_bit", uart_tx, 0);
        cyc = 2; dones = 0; t_prev = 0; dropped = 1'b0;
        while (dones < NL && cyc < 2000) begin
            @(negedge clk); cyc++;
            if (abort_byte == dones && cyc == 2 + abort_byte * PER + 5) begin
                check("line_low_mid_bit", uart_tx, 0);
                #2 rst = 1'b1;
                #1;
                check("rst_uart_tx", uart_tx, 1);
                check("rst_busy", busy, 0);
                check("rst_drop", drop, 0);
                lane_or = '0;
                for (int k = 0; k < NL; k++) lane_or = lane_or | dut.r_lane[k];
                check("rst_lanes_zero", lane_or, 0);
                @(posedge clk); @(posedge clk); #1; rst = 1'b0; sel = '0;
                exp_q.delete();
                for (int k = 0; k < NL; k++) m_lane[k] = '0;
                m_ptr = 0;
                return;
            end
            if (drop_byte == dones && !dropped && cyc > dones * PER + 10) begin
                out = 1'b1; dropped = 1'b1;
                @(negedge clk); cyc++; out = 1'b0;
            end
            if (!busy) begin
                check("byte_period", cyc - t_prev, PER);
                t_prev = cyc; dones++; sel = sel + 4'd1;
                if (dones < NL) begin
                    @(negedge clk); cyc++;
                    check("busy_low_one_cycle", busy, 1);
                end
            end
        end
        check("readback_complete", dones, NL);
        sel = '0;
    endtask

    // UART monitor: decode each frame at bit centres and compare against the scoreboard.
    initial begin
        logic [7:0] rx;
        bit ab;
        forever begin
            @(negedge clk);
            if (!rst && uart_tx == 1'b0) begin
                ab = 1'b0;
                rx = '0;
                for (int b = 0; b < 9; b++) begin
                    for (int k = 0; k < ((b == 0) ? CPB + 1 : CPB); k++) begin
                        @(negedge clk);
                        if (rst) ab = 1'b1;
                    end
                    if (b < 8) rx[b] = uart_tx;
                end
                if (!ab) begin
                    check("stop_bit", uart_tx, 1);
                    n_rx++;
                    if (exp_q.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL rx_unexpected: got 0x%0h, expected no byte", rx);
                    end else begin
                        check("rx_byte", rx, exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < NL; k++) m_lane[k] = '0;
        idle(3);
        rst = 1'b0;
        @(negedge clk);
        check("reset_uart_tx", uart_tx, 1);
        check("reset_busy", busy, 0);
        check("reset_drop", drop, 0);
        check("reset_ptr", dut.r_ptr, 0);

        // 1: single frame
        send_frame(8'hA5, 1);
        check("t1_lane0", dut.r_lane[0], 8'hA5);
        check("t1_ptr", dut.r_ptr, 1);
        check("t1_uart_idle", uart_tx, 1);
        check("t1_busy_idle", busy, 0);
        readback(-1, -1);
        idle(4);

        // 2: wrap and mod-256 accumulation
        for (int f = 0; f < 17; f++) send_frame(8'h01, 1);
        check("t2_lane0", dut.r_lane[0], 8'h02);
        check("t2_lane1", dut.r_lane[1], 8'h01);
        check("t2_lane15", dut.r_lane[15], 8'h01);
        check("t2_ptr_wrap", dut.r_ptr, 1);
        for (int f = 0; f < 256; f++) send_frame(8'h01, 1);
        check("t2_lane0_mod", dut.r_lane[0], 8'h12);
        check("t2_lane7_mod", dut.r_lane[7], 8'h11);
        readback(-1, -1);
        idle(4);

        // 3: partial frame discarded, surplus acc ignored
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1; acc = 1'b1; sdata = 1'b1;
        end
        send_frame(8'h3C, 1);
        check("t3_lane0", dut.r_lane[0], 8'h3C);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1; acc = 1'b1; sdata = i[0];
        end
        @(posedge clk); #1; acc = 1'b0;
        idle(2);
        check("t3_lane0_hold", dut.r_lane[0], 8'h3C);
        check("t3_lane1_hold", dut.r_lane[1], 8'h00);
        check("t3_ptr", dut.r_ptr, 1);
        readback(-1, -1);
        idle(4);

        // 4: full readback of 0x10..0x1F
        for (int k = 0; k < NL; k++) send_frame(8'h10 + 8'(k), 1);
        readback(-1, -1);
        idle(4);
        check("t4_fsm_idle", dut.r_state, IDLE);
        check("t4_drop_clear", drop, 0);
        for (int k = 0; k < NL; k++) check("t4_lane_zero", dut.r_lane[k], 0);

        // 5: out during lane 5 readback, and a frame racing the snapshot
        for (int k = 0; k < NL; k++) send_frame(8'h20 + 8'(k), 1);
        send_frame(8'h77, 0);
        readback(5, -1);
        idle(4);
        check("t5_drop", drop, 1);
        check("t5_lane0_race", dut.r_lane[0], 8'h77);
        check("t5_ptr", dut.r_ptr, 1);

        // 6: reset mid data bit of lane 3, then zero readback
        readback(-1, 3);
        idle(45);
        check("t6_drop_after_rst", drop, 0);
        readback(-1, -1);
        idle(8);
        check("rx_total", n_rx, 16 * 6 + 3);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
